// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared widths, midscale code and FSM state encoding for the feedback DAC modulator
package fb_pkg;

  localparam int CODE_W = 16;
  localparam int PWM_W  = 8;
  localparam logic [CODE_W-1:0] CODE_MID = 16'h8000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_dsm_acc.sv
// rtl/fb_dsm_acc.sv - first-order sigma-delta phase accumulator; carry is the unregistered overflow of acc + code
module fb_dsm_acc
  import fb_pkg::*;
#(
  parameter int CODE_W = fb_pkg::CODE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              step,
  input  logic [CODE_W-1:0] code,
  output logic              carry
);

  logic [CODE_W-1:0] acc;
  logic [CODE_W:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, code};
  assign carry = sum[CODE_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (step) begin
      acc <= sum[CODE_W-1:0];
    end
  end

endmodule

// File: rtl/fb_code_dsm.sv
// rtl/fb_code_dsm.sv - feedback code to 1-bit DAC drive, selectable sigma-delta or frame-based PWM
module fb_code_dsm
  import fb_pkg::*;
#(
  parameter int CODE_W = fb_pkg::CODE_W,
  parameter int PWM_W  = fb_pkg::PWM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code,
  input  logic              code_vld,
  input  logic              en,
  input  logic              mode,
  output logic              dac_bit,
  output logic              frame_start
);

  localparam logic [CODE_W-1:0] MID = {1'b1, {(CODE_W-1){1'b0}}};

  fb_state_e state, state_nxt;

  logic [CODE_W-1:0] code_sh;
  // Only the duty bits of the active PWM code are ever used, so only those are kept.
  logic [PWM_W-1:0]  code_act;
  logic [PWM_W-1:0]  cnt;
  logic              mode_q;
  logic              start;
  logic              dsm_step;
  logic              pwm_step;
  logic              carry;

  fb_dsm_acc #(.CODE_W(CODE_W)) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .step  (dsm_step),
    .code  (code_sh),
    .carry (carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    dsm_step  = 1'b0;
    pwm_step  = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = RUN;
          start     = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
        end else begin
          dsm_step = !mode_q;
          pwm_step = mode_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs default low, so any edge that is not a run step (IDLE, en drop) drives 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_sh     <= MID;
      code_act    <= MID[CODE_W-1 -: PWM_W];
      cnt         <= '0;
      mode_q      <= 1'b0;
      dac_bit     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      dac_bit     <= 1'b0;
      frame_start <= 1'b0;
      if (code_vld) begin
        code_sh <= code;
      end
      if (start) begin
        mode_q   <= mode;
        cnt      <= '0;
        code_act <= code_sh[CODE_W-1 -: PWM_W];
      end else if (pwm_step) begin
        cnt         <= cnt + 1'b1;
        dac_bit     <= (cnt < code_act);
        frame_start <= (cnt == '0);
        // Reload takes the pre-capture shadow value when code_vld lands on this edge.
        if (cnt == '1) begin
          code_act <= code_sh[CODE_W-1 -: PWM_W];
        end
      end else if (dsm_step) begin
        dac_bit <= carry;
      end
    end
  end

endmodule

// File: tb/tb_fb_code_dsm.sv
// tb/tb_fb_code_dsm.sv - directed table and sequence bench for fb_code_dsm
module tb_fb_code_dsm;
  import fb_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] code;
  logic        code_vld;
  logic        en;
  logic        mode;
  logic        dac_bit;
  logic        frame_start;

  int checks;
  int errors;

  typedef struct {
    logic        rst;
    logic        en;
    logic        mode;
    logic        vld;
    logic [15:0] code;
    logic        dac;
    logic        fs;
  } vec_t;

  vec_t tbl[17];

  fb_code_dsm #(.CODE_W(16), .PWM_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .code        (code),
    .code_vld    (code_vld),
    .en          (en),
    .mode        (mode),
    .dac_bit     (dac_bit),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b0; code_vld = 1'b0; code = 16'h0;
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [15:0] c);
    code_vld = 1'b1; code = c;
    tick();
    code_vld = 1'b0;
  endtask

  task automatic start_run(input logic m);
    en = 1'b1; mode = m;
    tick();
  endtask

  initial begin
    int bad;
    int ones;
    int fs_cnt;
    int fones[4];
    int duty[4];

    checks = 0;
    errors = 0;
    rst = 1'b1; en = 1'b0; mode = 1'b0; code_vld = 1'b0; code = 16'h0;

    //            rst  en   mode vld  code      dac  fs
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h4000, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; mode = tbl[i].mode;
      code_vld = tbl[i].vld; code = tbl[i].code;
      tick();
      check($sformatf("vec%0d_dac", i), {31'b0, dac_bit}, {31'b0, tbl[i].dac});
      check($sformatf("vec%0d_fs", i), {31'b0, frame_start}, {31'b0, tbl[i].fs});
    end
    check("rst_state", {31'b0, dut.state}, {31'b0, IDLE});
    check("rst_code_sh", {16'b0, dut.code_sh}, {16'b0, CODE_MID});

    // DSM midscale straight from reset value of the shadow register.
    do_reset();
    start_run(1'b0);
    bad = 0; ones = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      ones += int'(dac_bit);
      if (dac_bit !== ((i % 2) == 1)) bad++;
    end
    check("dsm_mid_pattern", bad, 0);
    check("dsm_mid_ones", ones, 128);

    do_reset();
    load(16'h4000);
    start_run(1'b0);
    bad = 0; ones = 0;
    for (int i = 0; i < 1024; i++) begin
      tick();
      ones += int'(dac_bit);
      if (dac_bit !== ((i % 4) == 3)) bad++;
    end
    check("dsm_quarter_pattern", bad, 0);
    check("dsm_quarter_ones", ones, 256);

    do_reset();
    load(16'h0000);
    start_run(1'b0);
    ones = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      ones += int'(dac_bit);
    end
    check("dsm_zero_ones", ones, 0);

    do_reset();
    load(16'h4000);
    start_run(1'b1);
    bad = 0; ones = 0; fs_cnt = 0;
    for (int i = 0; i < 512; i++) begin
      tick();
      ones += int'(dac_bit);
      fs_cnt += int'(frame_start);
      if (dac_bit !== ((i % 256) < 64)) bad++;
      if (frame_start !== ((i % 256) == 0)) bad++;
    end
    check("pwm_quarter_pattern", bad, 0);
    check("pwm_quarter_ones", ones, 128);
    check("pwm_quarter_fs", fs_cnt, 2);

    // Mid-frame update at cnt=100, then an update landing on the reload edge.
    do_reset();
    load(16'h4000);
    start_run(1'b1);
    duty[0] = 64; duty[1] = 192; duty[2] = 192; duty[3] = 64;
    for (int f = 0; f < 4; f++) fones[f] = 0;
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      code_vld = (i == 100) || (i == 511);
      code = (i == 100) ? 16'hC000 : 16'h4000;
      tick();
      fones[i / 256] += int'(dac_bit);
      if (dac_bit !== ((i % 256) < duty[i / 256])) bad++;
      if (frame_start !== ((i % 256) == 0)) bad++;
    end
    code_vld = 1'b0;
    check("pwm_update_pattern", bad, 0);
    for (int f = 0; f < 4; f++) check($sformatf("pwm_update_frame%0d_ones", f), fones[f], duty[f]);

    do_reset();
    load(16'hFF00);
    start_run(1'b1);
    ones = 0; fs_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      ones += int'(dac_bit);
      fs_cnt += int'(frame_start);
    end
    check("pwm_full_ones", ones, 255);
    check("pwm_full_last_bit", {31'b0, dac_bit}, 32'd0);
    tick();
    check("pwm_full_wrap_fs", {31'b0, frame_start}, 32'd1);
    check("pwm_full_wrap_dac", {31'b0, dac_bit}, 32'd1);

    do_reset();
    load(16'h0000);
    start_run(1'b1);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      ones += int'(dac_bit);
    end
    check("pwm_zero_ones", ones, 0);

    // Mode toggling in RUN is ignored; en drop and re-enable restart in the latched mode.
    do_reset();
    load(16'h4000);
    start_run(1'b1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      mode = ~mode;
      tick();
      if (dac_bit !== 1'b1) bad++;
      if (frame_start !== (i == 0)) bad++;
    end
    check("mode_toggle_ignored", bad, 0);
    en = 1'b0;
    tick();
    check("en_drop_dac", {31'b0, dac_bit}, 32'd0);
    check("en_drop_fs", {31'b0, frame_start}, 32'd0);
    start_run(1'b0);
    check("restart_dsm_start_dac", {31'b0, dac_bit}, 32'd0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dac_bit !== (i == 3)) bad++;
    end
    check("restart_dsm_pattern", bad, 0);
    en = 1'b0;
    tick();
    start_run(1'b1);
    tick();
    check("restart_pwm_fs", {31'b0, frame_start}, 32'd1);
    check("restart_pwm_dac", {31'b0, dac_bit}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
